// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the fetch/data memory arbiter
package mem_arbiter_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  localparam int BSEL_W = 2;

  localparam logic [BSEL_W-1:0] BYTESEL_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_INSTR,
    SERVE_DATA
  } MemArbState_t;

  typedef enum logic {
    GRANT_INSTR,
    GRANT_DATA
  } MemArbGrant_t;

  function automatic MemArbState_t serve_state(input MemArbGrant_t grant);
    return (grant == GRANT_DATA) ? SERVE_DATA : SERVE_INSTR;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// rtl/mem_arbiter_pick.sv - combinational grant chooser; MEM_ARBITER_RR_EN selects round-robin
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic instr_req,
  input  logic data_req,
  input  logic mask_valid,
  input  logic mask_grant,
  input  logic last_grant,
  output logic pick_valid,
  output logic pick_grant
);

  logic instr_ok;
  logic data_ok;

  // The port acked in the previous cycle is still showing its registered access.
  assign instr_ok = instr_req && !(mask_valid && (mask_grant == GRANT_INSTR));
  assign data_ok  = data_req  && !(mask_valid && (mask_grant == GRANT_DATA));

  always_comb begin
    pick_valid = instr_ok || data_ok;
    pick_grant = GRANT_INSTR;
`ifdef MEM_ARBITER_RR_EN
    if (instr_ok && data_ok) begin
      pick_grant = (last_grant == GRANT_DATA) ? GRANT_INSTR : GRANT_DATA;
    end else if (data_ok) begin
      pick_grant = GRANT_DATA;
    end
`else
    if (data_ok) begin
      pick_grant = GRANT_DATA;
    end
`endif
  end

`ifndef MEM_ARBITER_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data to single memory port arbiter; MEM_ARBITER_RR_EN enables round-robin
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [19:1]       instr_m_addr,
  input  logic              instr_m_access,
  output logic              instr_m_ack,
  output logic [15:0]       instr_m_data_in,
  input  logic [19:1]       data_m_addr,
  input  logic [15:0]       data_m_data_out,
  input  logic              data_m_access,
  input  logic              data_m_wr_en,
  input  logic [1:0]        data_m_bytesel,
  output logic              data_m_ack,
  output logic [15:0]       data_m_data_in,
  output logic [19:1]       q_m_addr,
  output logic [15:0]       q_m_data_out,
  input  logic [15:0]       q_m_data_in,
  output logic              q_m_access,
  input  logic              q_m_ack,
  output logic              q_m_wr_en,
  output logic [1:0]        q_m_bytesel
);

  MemArbState_t state;
  logic         mask_valid;
  MemArbGrant_t mask_grant;
  MemArbGrant_t last_grant;
  logic         pick_valid;
  logic         pick_grant_bit;
  MemArbGrant_t pick_grant;

  assign pick_grant = MemArbGrant_t'(pick_grant_bit);

  mem_arbiter_pick u_pick (
    .instr_req  (instr_m_access),
    .data_req   (data_m_access),
    .mask_valid (mask_valid),
    .mask_grant (mask_grant),
    .last_grant (last_grant),
    .pick_valid (pick_valid),
    .pick_grant (pick_grant_bit)
  );

`ifndef MEM_ARBITER_RR_EN
  assign last_grant = GRANT_DATA;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mask_valid <= 1'b0;
      mask_grant <= GRANT_INSTR;
`ifdef MEM_ARBITER_RR_EN
      last_grant <= GRANT_DATA;
`endif
    end else begin
      case (state)
        IDLE: begin
          mask_valid <= 1'b0;
          if (pick_valid) begin
            state <= serve_state(pick_grant);
`ifdef MEM_ARBITER_RR_EN
            last_grant <= pick_grant;
`endif
          end
        end
        SERVE_INSTR: begin
          if (q_m_ack) begin
            state      <= IDLE;
            mask_valid <= 1'b1;
            mask_grant <= GRANT_INSTR;
          end
        end
        SERVE_DATA: begin
          if (q_m_ack) begin
            state      <= IDLE;
            mask_valid <= 1'b1;
            mask_grant <= GRANT_DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

  // Memory side follows the state so it drops immediately when reset asserts.
  always_comb begin
    q_m_access   = 1'b0;
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = '0;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;
    case (state)
      SERVE_INSTR: begin
        q_m_access  = 1'b1;
        q_m_addr    = instr_m_addr;
        q_m_bytesel = BYTESEL_WORD;
        instr_m_ack = q_m_ack;
      end
      SERVE_DATA: begin
        q_m_access   = 1'b1;
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        data_m_ack   = q_m_ack;
      end
      default: ;
    endcase
  end

endmodule
